// File: rtl/water_tank_level_monitor_pkg.sv
// Shared types and pure helpers for the tank level monitor: FSM states,
// level width derivation and probe pattern classification.
package water_tank_pkg;

  typedef enum logic [1:0] {INIT, VALID, SUSPECT, FAULT} state_t;

  function automatic int level_width(input int num_sensors);
    return $clog2(num_sensors + 1);
  endfunction

  // A thermometer code is 2^k-1, so adding one clears every set bit.
  function automatic logic is_thermometer(input logic [15:0] v);
    return (v & (v + 16'd1)) == 16'd0;
  endfunction

  function automatic logic [4:0] ones_count(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) n = n + {4'd0, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/water_tank_level_monitor_if.sv
// Probe inputs and level/fault outputs of the tank monitor. The bench drives
// through master, the monitor sits on slave.
interface water_tank_level_monitor_if
  import water_tank_pkg::*;
#(
  parameter int NUM_SENSORS = 3
) ();
  localparam int LEVEL_W = level_width(NUM_SENSORS);

  logic [NUM_SENSORS-1:0] level_indicator_i;
  logic                   fault_clear_i;
  logic [LEVEL_W-1:0]     level_o;
  logic                   level_valid_o;
  logic                   level_changed_o;
  logic                   empty_o;
  logic                   full_o;
  logic                   fault_o;
  logic                   fault_sticky_o;

  modport master (
    output level_indicator_i, fault_clear_i,
    input  level_o, level_valid_o, level_changed_o, empty_o, full_o,
           fault_o, fault_sticky_o
  );

  modport slave (
    input  level_indicator_i, fault_clear_i,
    output level_o, level_valid_o, level_changed_o, empty_o, full_o,
           fault_o, fault_sticky_o
  );
endinterface

// File: rtl/water_tank_level_monitor_sensor_debouncer.sv
// One probe: 2-flop synchroniser followed by a debounce counter that only lets
// the filtered bit follow after DEBOUNCE_CYCLES consecutive disagreements.
module sensor_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic raw,
  output logic filt
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [1:0]    sync_pipe;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_pipe <= '0;
      cnt       <= '0;
      filt      <= 1'b0;
    end else begin
      sync_pipe <= {sync_pipe[0], raw};
      if (sync_pipe[1] == filt) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        filt <= sync_pipe[1];
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/water_tank_level_monitor.sv
// Tank level monitor: debounced probes, thermometer validation, binary level
// and a persistence-filtered fault with a sticky flag.
module water_tank_level_monitor
  import water_tank_pkg::*;
#(
  parameter int NUM_SENSORS     = 3,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FAULT_CYCLES    = 8
) (
  input logic                       clk_i,
  input logic                       rst_n_i,
  water_tank_level_monitor_if.slave bus
);
  localparam int LEVEL_W     = level_width(NUM_SENSORS);
  localparam int INIT_CYCLES = 2 + DEBOUNCE_CYCLES;
  localparam int IW          = $clog2(INIT_CYCLES);
  localparam int FW          = (FAULT_CYCLES > 1) ? $clog2(FAULT_CYCLES) : 1;

  logic [NUM_SENSORS-1:0] filt;
  logic                   pat_ok;
  logic [LEVEL_W-1:0]     pat_lvl;

  state_t             state, state_n;
  logic [IW-1:0]      init_cnt, init_n;
  logic [FW-1:0]      fcnt, fcnt_n;
  logic [LEVEL_W-1:0] level_q, level_n;
  logic               valid_q, valid_n;
  logic               changed_q, changed_n;
  logic               fault_q, fault_n;
  logic               sticky_q, sticky_n;

  for (genvar g = 0; g < NUM_SENSORS; g++) begin : g_probe
    sensor_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk_i  (clk_i),
      .rst_n_i(rst_n_i),
      .raw    (bus.level_indicator_i[g]),
      .filt   (filt[g])
    );
  end

  assign pat_ok  = is_thermometer(16'(filt));
  assign pat_lvl = LEVEL_W'(ones_count(16'(filt)));

  always_comb begin
    state_n   = state;
    init_n    = init_cnt;
    fcnt_n    = fcnt;
    level_n   = level_q;
    valid_n   = valid_q;
    changed_n = 1'b0;
    fault_n   = fault_q;
    unique case (state)
      INIT: begin
        valid_n = 1'b0;
        if (init_cnt != IW'(INIT_CYCLES - 1)) init_n = init_cnt + 1'b1;
      end
      SUSPECT: begin
        // n-th consecutive invalid sample sets fcnt to n-1; the FAULT_CYCLES-th faults
        if (!pat_ok) begin
          if (int'(fcnt) == FAULT_CYCLES - 2) begin
            state_n = FAULT;
            fault_n = 1'b1;
            valid_n = 1'b0;
          end else begin
            fcnt_n = fcnt + 1'b1;
          end
        end
      end
      FAULT: begin
        valid_n = 1'b0;
        fault_n = 1'b1;
      end
      default: ;
    endcase

    // Shared decisions: any valid pattern outside INIT's hold period is accepted,
    // and the first invalid sample after INIT or VALID starts the fault timer.
    if (state != INIT || init_cnt == IW'(INIT_CYCLES - 1)) begin
      if (pat_ok) begin
        state_n   = VALID;
        level_n   = pat_lvl;
        valid_n   = 1'b1;
        fault_n   = 1'b0;
        fcnt_n    = '0;
        changed_n = (pat_lvl != level_q);
      end else if (state == INIT || state == VALID) begin
        fcnt_n = '0;
        if (FAULT_CYCLES == 1) begin
          state_n = FAULT;
          fault_n = 1'b1;
          valid_n = 1'b0;
        end else begin
          state_n = SUSPECT;
        end
      end
    end

    if (state_n == FAULT && state != FAULT) sticky_n = 1'b1;
    else if (bus.fault_clear_i)             sticky_n = 1'b0;
    else                                    sticky_n = sticky_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= INIT;
      init_cnt  <= '0;
      fcnt      <= '0;
      level_q   <= '0;
      valid_q   <= 1'b0;
      changed_q <= 1'b0;
      fault_q   <= 1'b0;
      sticky_q  <= 1'b0;
    end else begin
      state     <= state_n;
      init_cnt  <= init_n;
      fcnt      <= fcnt_n;
      level_q   <= level_n;
      valid_q   <= valid_n;
      changed_q <= changed_n;
      fault_q   <= fault_n;
      sticky_q  <= sticky_n;
    end
  end

  assign bus.level_o         = level_q;
  assign bus.level_valid_o   = valid_q;
  assign bus.level_changed_o = changed_q;
  assign bus.empty_o         = valid_q && (level_q == '0);
  assign bus.full_o          = valid_q && (level_q == LEVEL_W'(NUM_SENSORS));
  assign bus.fault_o         = fault_q;
  assign bus.fault_sticky_o  = sticky_q;

endmodule

// File: tb/tb_water_tank_level_monitor.sv
// Directed scenarios plus randomized probe traffic, every cycle checked
// against a rule-level model of filtering, level tracking and fault timing.
module tb_water_tank_level_monitor;
  localparam int N = 3;
  localparam int D = 4;
  localparam int F = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  water_tank_level_monitor_if #(.NUM_SENSORS(N)) wif ();

  water_tank_level_monitor #(
    .NUM_SENSORS(N), .DEBOUNCE_CYCLES(D), .FAULT_CYCLES(F)
  ) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .bus    (wif)
  );

  int n_vec = 0;
  int n_err = 0;
  int pulses = 0;
  int faults_seen = 0;

  // reference model state
  logic [N-1:0] s1, s2, m_filt;
  int           m_run [N];
  int           since_rst, inv_run, m_level;
  bit           m_valid, m_changed, m_fault, m_sticky;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit therm(input logic [N-1:0] v);
    bit seen_zero;
    seen_zero = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!v[i]) seen_zero = 1'b1;
      else if (seen_zero) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    s1 = '0; s2 = '0; m_filt = '0;
    for (int i = 0; i < N; i++) m_run[i] = 0;
    since_rst = 0; inv_run = 0; m_level = 0;
    m_valid = 0; m_changed = 0; m_fault = 0; m_sticky = 0;
  endtask

  // Advance the model across one rising edge using pre-edge values.
  task automatic model_step();
    bit fault_now;
    int nl;
    if (!rst_n) begin model_reset(); return; end
    since_rst++;
    m_changed = 0;
    fault_now = m_fault;
    if (since_rst >= 2 + D) begin
      if (therm(m_filt)) begin
        nl = $countones(m_filt);
        m_changed = (nl != m_level);
        m_level = nl; m_valid = 1; fault_now = 0; inv_run = 0;
      end else begin
        inv_run++;
        if (inv_run >= F) begin fault_now = 1; m_valid = 0; end
      end
    end
    if (fault_now && !m_fault) m_sticky = 1;
    else if (wif.fault_clear_i) m_sticky = 0;
    m_fault = fault_now;
    for (int i = 0; i < N; i++) begin
      if (s2[i] != m_filt[i]) begin
        m_run[i]++;
        if (m_run[i] == D) begin m_filt[i] = s2[i]; m_run[i] = 0; end
      end else m_run[i] = 0;
    end
    s2 = s1;
    s1 = wif.level_indicator_i;
  endtask

  task automatic chk_all();
    chk("level",   32'(wif.level_o),         32'(m_level));
    chk("valid",   32'(wif.level_valid_o),   32'(m_valid));
    chk("changed", 32'(wif.level_changed_o), 32'(m_changed));
    chk("empty",   32'(wif.empty_o),         32'(m_valid && m_level == 0));
    chk("full",    32'(wif.full_o),          32'(m_valid && m_level == N));
    chk("fault",   32'(wif.fault_o),         32'(m_fault));
    chk("sticky",  32'(wif.fault_sticky_o),  32'(m_sticky));
  endtask

  // One clock: drive at negedge, model the edge, sample 1 time unit later.
  task automatic step(input logic [N-1:0] v, input logic clr);
    @(negedge clk);
    wif.level_indicator_i = v;
    wif.fault_clear_i     = clr;
    @(posedge clk);
    model_step();
    #1;
    chk_all();
    if (wif.level_changed_o) pulses++;
    if (wif.fault_o) faults_seen++;
  endtask

  task automatic hold(input logic [N-1:0] v, input int cyc);
    for (int k = 0; k < cyc; k++) step(v, 1'b0);
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_level",  32'(wif.level_o), 0);
    chk("rst_valid",  32'(wif.level_valid_o), 0);
    chk("rst_fault",  32'(wif.fault_o), 0);
    chk("rst_sticky", 32'(wif.fault_sticky_o), 0);
    chk("rst_empty",  32'(wif.empty_o), 0);
  endtask

  task automatic init_sequence();
    hold('0, 3);
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 1; k <= 8; k++) begin
      step('0, 1'b0);
      chk("init_valid", 32'(wif.level_valid_o), 32'(k >= 6));
    end
    chk("init_empty", 32'(wif.empty_o), 1);
    chk("init_pulse", 32'(pulses), 0);
  endtask

  initial begin
    logic [N-1:0] steps [3];
    logic [N-1:0] v;
    int           exp_lvl;
    wif.level_indicator_i = '0;
    wif.fault_clear_i     = 1'b0;
    model_reset();

    // 1: reset release, INIT hold
    init_sequence();

    // 2: staircase with exact 7-edge latency
    steps[0] = 3'b001; steps[1] = 3'b011; steps[2] = 3'b111;
    for (int s = 0; s < 3; s++) begin
      for (int k = 1; k <= 20; k++) begin
        step(steps[s], 1'b0);
        if (k == 6) chk("lat_before", 32'(wif.level_o), 32'(s));
        if (k == 7) begin
          chk("lat_level", 32'(wif.level_o), 32'(s + 1));
          chk("lat_pulse", 32'(wif.level_changed_o), 1);
        end
      end
    end
    chk("full_top", 32'(wif.full_o), 1);

    // 3: 3-cycle glitch on probe 1 is rejected
    hold(3'b001, 20);
    pulses = 0;
    hold(3'b011, 3);
    hold(3'b001, 20);
    chk("glitch_pulse", 32'(pulses), 0);
    chk("glitch_level", 32'(wif.level_o), 1);

    // 4: persistent invalid pattern faults, then recovers
    hold(3'b011, 20);
    hold(3'b101, 30);
    chk("fault_live", 32'(wif.fault_o), 1);
    chk("fault_sticky", 32'(wif.fault_sticky_o), 1);
    chk("fault_hold_lvl", 32'(wif.level_o), 2);
    pulses = 0;
    hold(3'b001, 20);
    chk("recover_level", 32'(wif.level_o), 1);
    chk("recover_pulse", 32'(pulses), 1);
    chk("recover_sticky", 32'(wif.fault_sticky_o), 1);
    step(3'b001, 1'b1);
    step(3'b001, 1'b0);
    chk("clear_sticky", 32'(wif.fault_sticky_o), 0);

    // 5: invalid for FAULT_CYCLES-1 filtered cycles does not fault
    hold(3'b000, 20);
    faults_seen = 0;
    pulses = 0;
    hold(3'b100, 7);
    hold(3'b000, 20);
    chk("short_invalid_fault", 32'(faults_seen), 0);
    chk("short_invalid_pulse", 32'(pulses), 0);

    // 6: async reset while in FAULT, then INIT timing again
    hold(3'b101, 30);
    chk("pre_reset_fault", 32'(wif.fault_o), 1);
    async_reset();
    init_sequence();

    // randomized traffic, mostly thermometer codes, with clears and resets
    for (int seg = 0; seg < 300; seg++) begin
      if ($urandom_range(0, 9) < 7) begin
        exp_lvl = $urandom_range(0, N);
        v = N'((1 << exp_lvl) - 1);
      end else begin
        v = N'($urandom);
      end
      for (int k = $urandom_range(1, 14); k > 0; k--)
        step(v, ($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 59) == 0) begin
        async_reset();
        hold(v, 2);
        rst_n = 1'b1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
